// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler draining four virtual-channel FIFOs into one
// output FIFO: up to W[n] consecutive pops per VC, empty VCs skipped, stalls on almost-full.
module wrr_vc_scheduler #(
  parameter int DW = 4,
  parameter int W0 = 4,
  parameter int W1 = 3,
  parameter int W2 = 2,
  parameter int W3 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enb,
  input  logic          empty_vchanel0,
  input  logic          empty_vchanel1,
  input  logic          empty_vchanel2,
  input  logic          empty_vchanel3,
  input  logic [DW-1:0] out_vchanel0,
  input  logic [DW-1:0] out_vchanel1,
  input  logic [DW-1:0] out_vchanel2,
  input  logic [DW-1:0] out_vchanel3,
  input  logic          almost_full_out,
  output logic          pop_vchanel0,
  output logic          pop_vchanel1,
  output logic          pop_vchanel2,
  output logic          pop_vchanel3,
  output logic [DW-1:0] out_wgthd_rndrobin,
  output logic          push_out,
  output logic [1:0]    arbiter,
  output logic          idle
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state_q;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    credit_q, credit_d;
  logic          push_q;
  logic [DW-1:0] data_q;

  logic [3:0]    empty_v;
  logic [3:0]    pop_v;
  logic [DW-1:0] data_sel;
  logic [1:0]    nxt;
  logic          any_ne;
  logic          pop_go;

  // Weights of 0 behave as 1 so a turn always yields at least one pop.
  function automatic logic [3:0] weight(input logic [1:0] idx);
    int w;
    case (idx)
      2'd0:    w = W0;
      2'd1:    w = W1;
      2'd2:    w = W2;
      default: w = W3;
    endcase
    if (w < 1)  w = 1;
    if (w > 15) w = 15;
    return w[3:0];
  endfunction

  // First non-empty VC after p (p+1, p+2, p+3), falling back to p itself.
  function automatic logic [1:0] next_vc(input logic [1:0] p, input logic [3:0] em);
    logic [1:0] c;
    next_vc = p;
    for (int k = 3; k >= 1; k--) begin
      c = p + 2'(k);
      if (!em[c]) next_vc = c;
    end
  endfunction

  assign empty_v = {empty_vchanel3, empty_vchanel2, empty_vchanel1, empty_vchanel0};
  assign any_ne  = ~&empty_v;
  assign nxt     = next_vc(ptr_q, empty_v);
  assign pop_go  = !rst && enb && !empty_v[ptr_q] && !almost_full_out;
  assign pop_v   = pop_go ? (4'b0001 << ptr_q) : 4'b0000;

  always_comb begin
    case (ptr_q)
      2'd0:    data_sel = out_vchanel0;
      2'd1:    data_sel = out_vchanel1;
      2'd2:    data_sel = out_vchanel2;
      default: data_sel = out_vchanel3;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (pop_go) begin
      if (credit_q > 4'd1) begin
        credit_d = credit_q - 4'd1;
      end else begin
        ptr_d    = nxt;
        credit_d = weight(nxt);
      end
    end else if (empty_v[ptr_q] && any_ne) begin
      ptr_d    = nxt;
      credit_d = weight(nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      credit_q <= weight(2'd0);
      push_q   <= 1'b0;
      data_q   <= '0;
    end else if (enb) begin
      case (state_q)
        IDLE:    if (any_ne)  state_q <= SERVE;
        default: if (!any_ne) state_q <= IDLE;
      endcase
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      push_q   <= pop_go;
      if (pop_go) data_q <= data_sel;
    end else begin
      push_q <= 1'b0;
    end
  end

  assign pop_vchanel0       = pop_v[0];
  assign pop_vchanel1       = pop_v[1];
  assign pop_vchanel2       = pop_v[2];
  assign pop_vchanel3       = pop_v[3];
  assign out_wgthd_rndrobin = data_q;
  assign push_out           = push_q;
  assign arbiter            = ptr_q;
  assign idle               = (state_q == IDLE);

endmodule

// File: tb/tb_wrr_vc_scheduler.sv
// Bench for wrr_vc_scheduler: VC FIFOs modelled as queues, directed sequences
// from the test plan, then randomized traffic against a reference model.
module tb_wrr_vc_scheduler;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst, enb, af;
  logic          em [4];
  logic [DW-1:0] od [4];
  logic          pop0, pop1, pop2, pop3;
  logic [DW-1:0] dout;
  logic          push;
  logic [1:0]    arb;
  logic          idl;

  wrr_vc_scheduler #(.DW(DW), .W0(4), .W1(3), .W2(2), .W3(1)) dut (
    .clk(clk), .rst(rst), .enb(enb),
    .empty_vchanel0(em[0]), .empty_vchanel1(em[1]),
    .empty_vchanel2(em[2]), .empty_vchanel3(em[3]),
    .out_vchanel0(od[0]), .out_vchanel1(od[1]),
    .out_vchanel2(od[2]), .out_vchanel3(od[3]),
    .almost_full_out(af),
    .pop_vchanel0(pop0), .pop_vchanel1(pop1),
    .pop_vchanel2(pop2), .pop_vchanel3(pop3),
    .out_wgthd_rndrobin(dout), .push_out(push),
    .arbiter(arb), .idle(idl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] vq [4][$];
  int            pat [$];
  int            obs_pop;

  // Reference model state
  int            m_ptr, m_credit;
  bit            m_idle, m_push;
  logic [DW-1:0] m_data;
  int            wts [4] = '{4, 3, 2, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wt(input int i);
    return (wts[i] < 1) ? 1 : wts[i];
  endfunction

  function automatic int nxt_vc(input int p, input bit [3:0] e);
    for (int k = 1; k <= 4; k++)
      if (!e[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_credit = wt(0); m_idle = 1; m_push = 0; m_data = '0;
  endtask

  // One clock cycle: drive VC flags from the queues, check at negedge, advance model.
  task automatic cycle();
    bit [3:0]   e;
    bit         any;
    int         exp_pop;
    logic [3:0] pv;
    for (int k = 0; k < 4; k++) begin
      e[k]  = (vq[k].size() == 0);
      em[k] = e[k];
      od[k] = e[k] ? DW'($urandom) : vq[k][0];
    end
    @(negedge clk);
    any     = (e != 4'hF);
    exp_pop = (!rst && enb && !e[m_ptr] && !af) ? m_ptr : 4;
    pv      = {pop3, pop2, pop1, pop0};
    chk("pop",  32'(pv),   (exp_pop == 4) ? 32'd0 : (32'd1 << exp_pop));
    chk("arb",  32'(arb),  32'(m_ptr));
    chk("idle", 32'(idl),  32'(m_idle));
    chk("push", 32'(push), 32'(m_push));
    chk("data", 32'(dout), 32'(m_data));
    case (pv)
      4'b0000: obs_pop = 4;
      4'b0001: obs_pop = 0;
      4'b0010: obs_pop = 1;
      4'b0100: obs_pop = 2;
      4'b1000: obs_pop = 3;
      default: obs_pop = 8;
    endcase
    if (rst) begin
      model_reset();
    end else if (enb) begin
      m_idle = !any;
      if (exp_pop != 4) begin
        m_data = vq[m_ptr].pop_front();
        m_push = 1;
        if (m_credit > 1) m_credit--;
        else begin
          m_ptr    = nxt_vc(m_ptr, e);
          m_credit = wt(m_ptr);
        end
      end else begin
        m_push = 0;
        if (e[m_ptr] && any) begin
          m_ptr    = nxt_vc(m_ptr, e);
          m_credit = wt(m_ptr);
        end
      end
    end else begin
      m_push = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n0, input int n1, input int n2, input int n3);
    int n [4];
    n = '{n0, n1, n2, n3};
    for (int k = 0; k < 4; k++) begin
      vq[k].delete();
      for (int i = 0; i < n[k]; i++) vq[k].push_back(DW'(k + 1));
    end
  endtask

  task automatic run_seq(input string name, input int n,
                         input logic [31:0] rs_m, input logic [31:0] af_m,
                         input logic [31:0] en_m);
    for (int i = 0; i < n; i++) begin
      rst = rs_m[i]; af = af_m[i]; enb = en_m[i];
      cycle();
      chk(name, 32'(obs_pop), 32'(pat[i]));
    end
    rst = 0; af = 0; enb = 1;
  endtask

  initial begin
    rst = 1; enb = 1; af = 0;
    for (int k = 0; k < 4; k++) begin em[k] = 1; od[k] = '0; end
    @(posedge clk); #1;
    model_reset();

    // Steady state, all VCs busy: 4/3/2/1 rotation
    load(40, 40, 40, 40);
    pat = '{4, 0,0,0,0,1,1,1,2,2,3, 0,0,0,0,1,1,1,2,2,3};
    run_seq("rot", 21, 32'h1, 32'h0, 32'hFFFF_FFFF);

    // VC0 runs dry after 2 pops: one bubble, then skipped
    load(2, 40, 40, 40);
    pat = '{4, 0,0,4,1,1,1,2,2,3,1,1,1,2};
    run_seq("skip", 14, 32'h1, 32'h0, 32'hFFFF_FFFF);

    // Only VC2 has data, starting from IDLE
    load(0, 0, 30, 0);
    pat = '{4, 4, 2,2,2,2,2,2,2};
    run_seq("solo", 9, 32'h1, 32'h0, 32'hFFFF_FFFF);

    // Backpressure mid-VC1 turn
    load(40, 40, 40, 40);
    pat = '{4, 0,0,0,0,1,4,4,4,1,1,2,2,3};
    run_seq("afull", 14, 32'h1, 32'h1C0, 32'hFFFF_FFFF);

    // Enable dropped mid-VC0 turn
    load(40, 40, 40, 40);
    pat = '{4, 0,0,4,4,0,0,1};
    run_seq("enb", 8, 32'h1, 32'h0, ~32'h18);

    // Reset during a VC2 turn
    load(40, 40, 40, 40);
    pat = '{4, 0,0,0,0,1,1,1,2,4,0,0,0,0,1};
    run_seq("rstmid", 15, 32'h201, 32'h0, 32'hFFFF_FFFF);

    // Randomized traffic
    for (int k = 0; k < 4; k++) vq[k].delete();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if (vq[k].size() < 6 && $urandom_range(0, 2) == 0) vq[k].push_back(DW'($urandom));
      rst = ($urandom_range(0, 149) == 0);
      af  = ($urandom_range(0, 4) == 0);
      enb = ($urandom_range(0, 7) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_vc_scheduler.md
Name: wrr_vc_scheduler

Overview:
- Weighted round-robin scheduler for the four virtual-channel FIFOs (VC0..VC3) feeding one shared 4-bit output FIFO.
- Pops a word from the granted VC and forwards it registered to the output FIFO.
- Grants each VC up to its weight in consecutive pops, then rotates; skips empty VCs; stalls on downstream almost-full.

Parameters:
- DW, 4, data width of every VC and of the output.
- W0, 4, pops per turn for VC0 (legal 1..15; 0 treated as 1).
- W1, 3, pops per turn for VC1 (legal 1..15; 0 treated as 1).
- W2, 2, pops per turn for VC2 (legal 1..15; 0 treated as 1).
- W3, 1, pops per turn for VC3 (legal 1..15; 0 treated as 1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- enb  in  1  enable; low freezes all state, no pops.
- empty_vchanel0..3  in  1 each  VC FIFO empty flags.
- out_vchanel0..3  in  DW each  VC FIFO show-ahead data, valid whenever its empty=0.
- almost_full_out  in  1  output FIFO almost-full backpressure.
- pop_vchanel0..3  out  1 each  pop strobes, combinational from state and inputs, at most one high.
- out_wgthd_rndrobin  out  DW  registered data toward the output FIFO.
- push_out  out  1  registered push strobe qualifying out_wgthd_rndrobin.
- arbiter  out  2  current grant pointer (registered).
- idle  out  1  high in IDLE state.

Behaviour:
- Reset (rst=1 at a clk edge): arbiter=0, credit=W0, state=IDLE, push_out=0, out_wgthd_rndrobin=0.
- Pops are forced to 0 while rst=1, independent of other inputs.
- Internal state: arbiter ptr[1:0], credit[3:0], FSM {IDLE, SERVE}.
- "next(p)": first VC with empty=0, searching p+1, p+2, p+3 (mod 4), then p itself. None found = all empty.
- Per cycle with enb=1 and rst=0:
  - pop condition = !empty[ptr] && !almost_full_out.
  - If pop condition: pop_vchanel[ptr]=1. Next edge: out_wgthd_rndrobin<=out_vchanel[ptr], push_out<=1.
    - If credit>1: credit decrements, ptr holds.
    - If credit==1: ptr<=next(ptr), credit<=W[next(ptr)], evaluated on the current empty flags. If all are empty, ptr holds and credit reloads with W[ptr].
  - If empty[ptr]=1: no pop, push_out<=0.
    - If some VC is non-empty: ptr<=next(ptr), credit<=W[new ptr]. This costs one bubble cycle.
    - If all are empty: state<=IDLE, ptr and credit hold.
  - If !empty[ptr] and almost_full_out=1: no pop, push_out<=0, ptr and credit frozen.
- FSM:
  - IDLE -> SERVE when any VC is non-empty.
  - SERVE -> IDLE when all are empty at an edge.
  - idle=1 only in IDLE.
  - Pop decisions ignore FSM state; the FSM is status only.
- enb=0: all pops 0, push_out<=0, every other register holds.
- Latency: pop to push_out/data is 1 cycle. At most one word per cycle.
- Fairness: with all VCs continuously non-empty and no backpressure, a 4+3+2+1 = 10-cycle period.
- Reset mid-burst: restarts at VC0 with credit W0. A push pending from the previous cycle is dropped (push_out=0 after reset).
- Credit never underflows; ptr wraps 3->0.

Test Plan:
- Defaults, all four VCs non-empty with distinct data 0x1/0x2/0x3/0x4, almost_full_out=0, enb=1 after reset -> pop/arbiter sequence 0,0,0,0,1,1,1,2,2,3 repeating. push_out high every cycle from the second pop; out_wgthd_rndrobin follows with 1-cycle lag.
- VC0 empties after 2 pops, others full -> 1 bubble cycle (no pop) with arbiter->1; then VC1 gets 3 pops, VC2 2, VC3 1, and VC0 is skipped while empty.
- Only VC2 non-empty from IDLE (arbiter=0) -> next edge arbiter=2, idle=0. Pops on VC2 every cycle; credit reloads W2 each time it reaches 1, with no bubbles.
- almost_full_out high for 3 cycles mid-VC1 turn (credit=2) -> no pops, push_out=0 for those cycles. On release, VC1 gets exactly 2 more pops, then VC2.
- enb=0 for 2 cycles mid-VC0 turn -> pops 0, push_out=0, arbiter/credit unchanged. Resumes the remaining VC0 credit.
- rst pulse during a VC2 turn -> next cycle arbiter=0, push_out=0, out_wgthd_rndrobin=0. The sequence restarts with 4 pops of VC0.
